press_scheduler: RTL and testbench
==================================

# press_scheduler

Round-robin scheduler that shares the single press-counting resource among `N_REQ` button requesters. It grants one requester at a time, counts accepted presses and records the winner's index. It also runs an inactivity watchdog that locks the block into an error state after `TIMEOUT` consecutive idle cycles. It sits between the debounced button inputs and the display/counter logic, and extends the single-button press FSM to multiple sources.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, from 2 to 8.
- `TIMEOUT`, default 100: number of consecutive idle cycles before lockout, from 2 to 255.
- `CNT_W`, default 8: width of the press counter.

Ports:
- `clk`, input, 1: the single system clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, `N_REQ`: level press requests, one bit per button.
- `grant`, output, `N_REQ`: one-hot grant, high for exactly one cycle per accepted press.
- `last_id`, output, `$clog2(N_REQ)`: index of the most recently granted requester.
- `count`, output, `CNT_W`: total accepted presses.
- `busy`, output, 1: high whenever the state is not IDLE.
- `err`, output, 8: 8'hFF in ERROR, otherwise 8'h00.

## Operation
Internal registers:
- `state`
- `ptr`: the round-robin start index
- `idle_cnt`: 8-bit watchdog counter
- `cur_id`: the currently served requester

The state machine has four states.
- IDLE:
  - If `req` is nonzero: select the first asserted bit scanning `ptr`, `ptr+1`, and so on, modulo `N_REQ`. Then `cur_id` takes the selected index, `idle_cnt` takes 0 and the next state is GRANT.
  - Else if `idle_cnt == TIMEOUT-1`: the next state is ERROR.
  - Else: `idle_cnt` increments by 1.
- GRANT (exactly 1 cycle):
  - `grant[cur_id]` is 1.
  - `count` increments by 1 and wraps from all-ones to 0.
  - `last_id` takes `cur_id`.
  - `ptr` takes `(cur_id+1) mod N_REQ`.
  - The next state is HOLD.
- HOLD:
  - Wait for `req[cur_id]` to go 0, then go to IDLE.
  - Other requests are ignored and not queued. They are re-evaluated in IDLE.
  - `idle_cnt` is held at 0.
- ERROR:
  - `err` is 8'hFF; `grant` is 0; `busy` is 1.
  - `req` is ignored.
  - Only `rst` exits this state.

Rules:
- A requester holding `req` high gets exactly one grant per assertion; it must drop `req` before it can be granted again.
- Fairness: after requester i is served, every other requester that is asserting in IDLE is served before i again.
- IDLE counts toward the watchdog only on cycles where `req == 0`. Any request clears the watchdog via the transition to GRANT.
- Reset values:
  - `state` IDLE, `ptr` 0, `idle_cnt` 0, `cur_id` 0
  - `grant` 0, `last_id` 0, `count` 0, `busy` 0, `err` 8'h00
- Reset mid-operation: asserting `rst` in any state, including GRANT and ERROR, forces all reset values immediately, without waiting for a clock edge. It also cancels a pending grant.

## Timing
- All outputs are registered. `grant`, `count` and `last_id` change on the same edge that enters GRANT.
- Latency: `req` sampled high at edge k in IDLE gives `grant` high during cycle k to k+1, and low again after edge k+1.
- The minimum spacing between two grants is 3 cycles: GRANT, one HOLD cycle with `req` already low, then IDLE evaluation. This holds when the next requester is already asserting.
- Watchdog: if the block enters IDLE at edge e and `req` stays 0, ERROR is entered at edge e+`TIMEOUT`. `err` is 8'hFF from that edge.
- A request arriving on the same cycle that `idle_cnt == TIMEOUT-1` wins: the next state is GRANT, not ERROR.
- Two or more simultaneous requests are resolved by `ptr` order in the same cycle, with no extra latency.
- `rst` deassertion is synchronous to the next rising edge; the first IDLE evaluation happens at the first edge after release.

## Test plan
1. Reset, then pulse `req=4'b0100` for 2 cycles. Expect `grant=4'b0100` for 1 cycle, `count=1`, `last_id=2`. The next `ptr` is 3.
2. Hold `req=4'b1111` continuously, dropping each bit 1 cycle after its grant. Expect the grant order 0, 1, 2, 3, then `count=4` with no requester repeated.
3. Hold `req[1]` high for 20 cycles. Expect exactly one grant, `busy=1` throughout HOLD, and `count` to increase by 1 only.
4. Apply `req=0` for 99 cycles after reset. Expect `err=0`. On the 100th idle cycle expect `err=8'hFF`. Afterwards `req=4'b0001` gives no grant and `count` is unchanged; asserting `rst` returns `err=0` and `count=0`.
5. Assert `req[0]` exactly on the cycle `idle_cnt=99`. Expect a grant and no ERROR; `idle_cnt` returns to 0.
6. Issue 256 single-requester presses with `CNT_W=8`. Expect `count` to wrap to 0. Then assert `rst` asynchronously mid-GRANT; expect `grant` to drop immediately and all outputs to take their reset values.

Source files
------------

// File: rtl/press_scheduler.sv
// Round-robin press scheduler: shares one press counter among N_REQ buttons,
// grants one requester per assertion and locks up after TIMEOUT idle cycles.
module press_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 100,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] last_id,
    output logic [CNT_W-1:0]         count,
    output logic                     busy,
    output logic [7:0]               err
);

    localparam int ID_W = $clog2(N_REQ);
    localparam logic [ID_W:0]   N_WIDE  = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);
    localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [ID_W-1:0]    ptr_reg, ptr_next;
    logic [7:0]         idle_cnt_reg, idle_cnt_next;
    logic [ID_W-1:0]    cur_id_reg, cur_id_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [ID_W-1:0]    last_id_reg, last_id_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               busy_reg;
    logic [7:0]         err_reg;

    // Requests rotated so that position 0 is the requester at ptr.
    logic [ID_W-1:0]    rot_idx [N_REQ];
    logic [N_REQ-1:0]   req_rot;
    logic               sel_valid;
    logic [ID_W-1:0]    sel_id;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [ID_W:0] sum;
            assign sum         = {1'b0, ptr_reg} + (ID_W+1)'(gi);
            assign rot_idx[gi] = (sum >= N_WIDE) ? ID_W'(sum - N_WIDE) : ID_W'(sum);
            assign req_rot[gi] = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        sel_valid = 1'b0;
        sel_id    = ptr_reg;
        for (int k = 0; k < N_REQ; k++) begin
            if (!sel_valid && req_rot[k]) begin
                sel_valid = 1'b1;
                sel_id    = rot_idx[k];
            end
        end
    end

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (id == ID_LAST) ? '0 : id + 1'b1;
    endfunction

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        idle_cnt_next = idle_cnt_reg;
        cur_id_next   = cur_id_reg;
        grant_next    = '0;
        last_id_next  = last_id_reg;
        count_next    = count_reg;

        unique case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    // Grant outputs, counter and pointer all update on the edge entering GRANT.
                    state_next          = GRANT;
                    cur_id_next         = sel_id;
                    idle_cnt_next       = '0;
                    grant_next[sel_id]  = 1'b1;
                    count_next          = count_reg + 1'b1;
                    last_id_next        = sel_id;
                    ptr_next            = wrap_inc(sel_id);
                end else if (idle_cnt_reg == TO_LAST) begin
                    state_next = ERROR;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 8'd1;
                end
            end
            GRANT: begin
                state_next = HOLD;
            end
            HOLD: begin
                idle_cnt_next = '0;
                if (!req[cur_id_reg]) begin
                    state_next = IDLE;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            idle_cnt_reg <= '0;
            cur_id_reg   <= '0;
            grant_reg    <= '0;
            last_id_reg  <= '0;
            count_reg    <= '0;
            busy_reg     <= 1'b0;
            err_reg      <= 8'h00;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            idle_cnt_reg <= idle_cnt_next;
            cur_id_reg   <= cur_id_next;
            grant_reg    <= grant_next;
            last_id_reg  <= last_id_next;
            count_reg    <= count_next;
            busy_reg     <= (state_next != IDLE);
            err_reg      <= (state_next == ERROR) ? 8'hFF : 8'h00;
        end
    end

    assign grant   = grant_reg;
    assign last_id = last_id_reg;
    assign count   = count_reg;
    assign busy    = busy_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_press_scheduler.sv
// Directed bench for press_scheduler (N_REQ=4, TIMEOUT=100, CNT_W=8) with
// hand-computed expectations for grant order, watchdog and reset behaviour.
module tb_press_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] last_id;
    logic [7:0] count;
    logic       busy;
    logic [7:0] err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    press_scheduler #(
        .N_REQ  (4),
        .TIMEOUT(100),
        .CNT_W  (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .grant  (grant),
        .last_id(last_id),
        .count  (count),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
            $display("ok   %-22s got %0h", tag, obs);
        end else begin
            $display("FAIL %-22s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (grant != 4'b0000) break;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int         gcount;
    logic [3:0] gsum;

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_grant", grant, 4'b0000);
        check("rst_count", count, 8'd0);
        check("rst_last_id", last_id, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 8'h00);
        rst = 1'b0;

        // 1: single request on bit 2, one-cycle latency
        req = 4'b0100;
        tick();
        check("t1_grant", grant, 4'b0100);
        check("t1_count", count, 8'd1);
        check("t1_last_id", last_id, 2'd2);
        check("t1_busy", busy, 1'b1);
        tick();
        check("t1_grant_1cyc", grant, 4'b0000);
        req = 4'b0000;
        tick();
        check("t1_back_idle", busy, 1'b0);
        // ptr is now 3: with bits 0 and 3 asserted, 3 wins, then 0
        req = 4'b1001;
        wait_grant(10);
        check("t1_ptr3_grant", grant, 4'b1000);
        check("t1_ptr3_last_id", last_id, 2'd3);
        req = 4'b0001;
        wait_grant(10);
        check("t1_next_grant", grant, 4'b0001);
        req = 4'b0000;
        tick();
        tick();

        // 2: all four requesting, each drops right after its grant
        do_reset();
        req = 4'b1111;
        for (int id = 0; id < 4; id++) begin
            wait_grant(10);
            check($sformatf("t2_order_%0d", id), grant, 4'b0001 << id);
            req[id] = 1'b0;
        end
        check("t2_count", count, 8'd4);
        check("t2_last_id", last_id, 2'd3);
        gsum = 4'b0000;
        repeat (6) begin
            tick();
            gsum |= grant;
        end
        check("t2_no_repeat", gsum, 4'b0000);

        // 3: held request yields a single grant
        do_reset();
        gcount = 0;
        req = 4'b0010;
        repeat (20) begin
            tick();
            if (grant != 4'b0000) gcount++;
        end
        check("t3_one_grant", gcount, 1);
        check("t3_busy_hold", busy, 1'b1);
        check("t3_count", count, 8'd1);
        req = 4'b0000;
        tick();
        tick();
        check("t3_idle_again", busy, 1'b0);
        check("t3_count_after", count, 8'd1);

        // 4: watchdog lockout after 100 idle cycles
        do_reset();
        repeat (99) tick();
        check("t4_err_99", err, 8'h00);
        tick();
        check("t4_err_100", err, 8'hFF);
        check("t4_busy_err", busy, 1'b1);
        req = 4'b0001;
        gsum = 4'b0000;
        repeat (5) begin
            tick();
            gsum |= grant;
        end
        check("t4_no_grant", gsum, 4'b0000);
        check("t4_count_same", count, 8'd0);
        check("t4_still_err", err, 8'hFF);
        rst = 1'b1;
        #1;
        check("t4_rst_err", err, 8'h00);
        check("t4_rst_busy", busy, 1'b0);
        req = 4'b0000;
        tick();
        rst = 1'b0;

        // 5: request on the last idle cycle wins over lockout
        do_reset();
        repeat (99) tick();
        req = 4'b0001;
        tick();
        check("t5_grant", grant, 4'b0001);
        check("t5_err", err, 8'h00);
        req = 4'b0000;
        repeat (101) tick();
        check("t5_wd_restart", err, 8'h00);
        tick();
        check("t5_wd_expire", err, 8'hFF);

        // 6: counter wrap after 256 presses, then async reset mid-GRANT
        do_reset();
        for (int i = 0; i < 256; i++) begin
            req = 4'b0001;
            tick();
            if (i == 254) check("t6_count_255", count, 8'd255);
            req = 4'b0000;
            tick();
            tick();
        end
        check("t6_count_wrap", count, 8'd0);
        check("t6_last_id", last_id, 2'd0);
        req = 4'b0001;
        tick();
        check("t6_grant_pre", grant, 4'b0001);
        check("t6_count_pre", count, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_arst_grant", grant, 4'b0000);
        check("t6_arst_count", count, 8'd0);
        check("t6_arst_last_id", last_id, 2'd0);
        check("t6_arst_busy", busy, 1'b0);
        check("t6_arst_err", err, 8'h00);
        req = 4'b0000;
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
